lvds_rx_deser: RTL
==================

LVDS_RX_DESER -- requirements
Module: lvds_rx_deser

Interface
REQ-001 SHALL have parameter LANES, default 4, number of LVDS data lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bits per sample per lane (even, at least 4).
REQ-003 SHALL have parameter FFT_SIZE, default 256, samples per burst for out_last.
REQ-004 SHALL have port clock, input, 1, forwarded LVDS bit clock after capture; one clock only.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low.
REQ-006 SHALL have port i_data_r, input, LANES, per-lane bit captured on the rising edge.
REQ-007 SHALL have port i_data_f, input, LANES, per-lane bit captured on the following falling edge.
REQ-008 SHALL have ports i_valid_r / i_valid_f, input, 1 each, valid line captured on rising / falling edge.
REQ-009 SHALL have ports i_frame_r / i_frame_f, input, 1 each, frame line captured on rising / falling edge.
REQ-010 SHALL have port out_data, output, LANES*DATA_WIDTH, lane n sample in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have ports out_valid (output, 1) / out_ready (input, 1), ready/valid handshake.
REQ-012 SHALL have port out_last, output, 1, set on burst sample FFT_SIZE-1.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on framing violation.
REQ-014 SHALL have port overflow, output, 1, sticky; set on word dropped for lack of buffer space.

Function
REQ-015 SHALL treat each clock cycle as one bit pair: i_*_r = bit 2p, i_*_f = bit 2p+1, p = pair index 0..DATA_WIDTH/2-1; LSB first.
REQ-016 SHALL encode framing as frame=1 on bits 0..DATA_WIDTH/2-1 and frame=0 on the remaining bits; valid=1 on every bit of a word.
REQ-017 SHALL implement states HUNT and RECV.
REQ-018 SHALL leave HUNT for RECV, pair index 0, in the cycle where all four valid/frame inputs are 1 and the registered previous i_frame_f is 0.
REQ-019 SHALL, in RECV, shift lane pairs into per-lane shift registers and increment the pair index each cycle.
REQ-020 SHALL pulse frame_err and return to HUNT, discarding the partial word, if frame or valid mismatches REQ-016 in any half of any pair.
REQ-021 SHALL, at the last pair, push the assembled word into the output buffer; this is the word-complete event.
REQ-022 SHALL, in the cycle after word-complete, go to RECV pair 0 if the start condition of REQ-018 holds; if valid_r=valid_f=0, go to HUNT without frame_err; otherwise pulse frame_err and go to HUNT.
REQ-023 SHALL assert out_valid the cycle after word-complete when the buffer was empty, giving latency 1 cycle from the final bit pair.
REQ-024 SHALL use a 2-entry FIFO output buffer; a transfer occurs when out_valid and out_ready are both 1 on a clock edge.
REQ-025 SHALL, when the buffer is full, accept a word-complete push in a cycle that also pops; otherwise drop the word and set overflow.
REQ-026 SHALL count pushed words modulo FFT_SIZE, tag the word with count FFT_SIZE-1 as last, and wrap to 0.
REQ-027 SHALL clear the sample count to 0 on an idle exit to HUNT (REQ-022 valid=0) or a frame_err; dropped words still advance the count.

Reset
REQ-028 SHALL, on reset low at a clock edge, enter HUNT and clear the pair index, sample count, shift registers and FIFO.
REQ-029 SHALL drive out_valid=0, out_last=0, out_data=0, frame_err=0 and overflow=0 while in reset.
REQ-030 SHALL, on reset mid-word, discard the partial word and require a fresh start condition.

Structure
REQ-031 SHALL take LANES, DATA_WIDTH, FFT_SIZE defaults and the state encoding from the shared lvds_pkg package.
REQ-032 SHALL instantiate one sub-module, lvds_rx_fifo2: a 2-entry ready/valid FIFO carrying {last, data}.

Verification
REQ-033 SHALL cover this case: one burst of 256 words with all lanes continuous and out_ready=1, lane0 = {i,8'hF0}, lane3 = {i,8'hF3} -> 256 outputs in order; out_last only on i=255; frame_err=0.
REQ-034 SHALL cover this case: valid low for 3 cycles, then a word on lane1 = 16'h1234 -> single output 16'h1234 one cycle after its last pair; out_last=0.
REQ-035 SHALL cover this case: frame forced 0 at pair 2 -> frame_err pulse for 1 cycle; no output; the next clean word is received correctly.
REQ-036 SHALL cover this case: out_ready=0 across 3 words -> first two words held in order; overflow=1 after the third; after ready=1 exactly 2 words are emitted.
REQ-037 SHALL cover this case: reset low at pair 5 of a word -> out_valid=0 next cycle; the next complete word is output with sample count 0.
REQ-038 SHALL cover this case: 255 words, valid gap, then 256 words -> the first burst has no out_last; the second burst asserts out_last on its 256th word.

Source files
------------

// File: rtl/lvds_pkg.sv
// lvds_pkg: shared defaults, receiver states and framing helper for the LVDS deserializer
package lvds_pkg;
  localparam int LVDS_LANES      = 4;
  localparam int LVDS_DATA_WIDTH = 16;
  localparam int LVDS_FFT_SIZE   = 256;
  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} rx_state_t;
  function automatic logic frame_bit(input int b, input int dw);
    return b < dw / 2;
  endfunction
endpackage

// File: rtl/lvds_rx_fifo2.sv
// lvds_rx_fifo2: two-entry ready/valid buffer
module lvds_rx_fifo2 #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;
  assign o_valid = r_cnt != 2'd0;
  assign o_data  = r_mem[r_rp];
  assign w_pop   = o_valid & i_ready;
  assign o_ready = (r_cnt != 2'd2) | w_pop;
  assign w_push  = i_valid & o_ready;
  // Pointer and occupancy update; a push into a full buffer rides on a same-cycle pop
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_data;
      r_wp  <= r_wp ^ w_push;
      r_rp  <= r_rp ^ w_pop;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/lvds_rx_deser.sv
// lvds_rx_deser: DDR LVDS lane deserializer with frame tracking and a 2-deep output buffer
module lvds_rx_deser
  import lvds_pkg::*;
#(
  parameter int LANES      = LVDS_LANES,
  parameter int DATA_WIDTH = LVDS_DATA_WIDTH,
  parameter int FFT_SIZE   = LVDS_FFT_SIZE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LANES-1:0]            i_data_r,
  input  logic [LANES-1:0]            i_data_f,
  input  logic                        i_valid_r,
  input  logic                        i_valid_f,
  input  logic                        i_frame_r,
  input  logic                        i_frame_f,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        frame_err,
  output logic                        overflow
);
  localparam int PAIRS = DATA_WIDTH / 2;
  localparam int PW    = $clog2(PAIRS);
  localparam int CW    = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
  localparam int W     = LANES * DATA_WIDTH;
  rx_state_t             r_state;
  logic [PW-1:0]         r_pair;
  logic [DATA_WIDTH-3:0] r_sh [LANES];
  logic [CW-1:0]         r_cnt;
  logic                  r_prev_ff, r_frame_err, r_overflow;
  logic                  w_start, w_idle, w_ok, w_boundary, w_take, w_done, w_err;
  logic                  w_last, w_fifo_ready, w_fifo_valid, w_q_last;
  logic [W-1:0]          w_word, w_q_data;
  assign w_start    = i_valid_r & i_valid_f & i_frame_r & i_frame_f & ~r_prev_ff;
  assign w_idle     = ~i_valid_r & ~i_valid_f;
  assign w_ok       = i_valid_r & i_valid_f &
                      (i_frame_r == frame_bit(2 * int'(r_pair), DATA_WIDTH)) &
                      (i_frame_f == frame_bit(2 * int'(r_pair) + 1, DATA_WIDTH));
  assign w_boundary = (r_state == HUNT) | (r_pair == '0);
  assign w_take     = w_boundary ? w_start : w_ok;
  assign w_done     = (r_state == RECV) & (r_pair == PW'(PAIRS - 1)) & w_ok;
  assign w_err      = (r_state == RECV) & ~w_take & ~((r_pair == '0) & w_idle);
  assign w_last     = r_cnt == CW'(FFT_SIZE - 1);
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign w_word[n*DATA_WIDTH +: DATA_WIDTH] = {i_data_f[n], i_data_r[n], r_sh[n]};
  end
  // Previous falling-edge frame bit, so a start needs a fresh rising edge of frame
  always_ff @(posedge clock) r_prev_ff <= i_frame_f;
  // Receive FSM: pair tracking, lane shift, burst count, error and overflow flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_pair      <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      for (int n = 0; n < LANES; n++) r_sh[n] <= '0;
    end else begin
      r_state     <= w_take ? RECV : HUNT;
      r_pair      <= (w_take & ~w_done) ? r_pair + 1'b1 : '0;
      r_frame_err <= w_err;
      r_overflow  <= r_overflow | (w_done & ~w_fifo_ready);
      if (r_state == RECV && !w_take) r_cnt <= '0;
      else if (w_done) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_take && !w_done)
        for (int n = 0; n < LANES; n++) r_sh[n][{r_pair, 1'b0} +: 2] <= {i_data_f[n], i_data_r[n]};
    end
  end
  lvds_rx_fifo2 #(.W(W + 1)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .i_data ({w_last, w_word}),
    .i_valid(w_done),
    .o_ready(w_fifo_ready),
    .o_data ({w_q_last, w_q_data}),
    .o_valid(w_fifo_valid),
    .i_ready(out_ready)
  );
  assign out_valid = w_fifo_valid;
  assign out_data  = w_fifo_valid ? w_q_data : '0;
  assign out_last  = w_fifo_valid & w_q_last;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
endmodule
